dma_copy_engine: RTL

- Word-granular bus initiator for the core data bus (bus_lock / memory_mode / data_address / data_mask / data_out / data_in). It sits opposite the memory-mapped responders: BRAM, switch/button registers and the LED register.
- Copies a block of words from a source to a destination, or fills a destination with a constant.
- Arbitration against the core is external: a mux selects this block's bus outputs while busy=1.

---
 rtl/dma_copy_engine.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/dma_copy_engine.sv
// Word-granular bus initiator that copies a block of words from a source to a
// destination, or fills a destination with a constant. All bus outputs are
// registered. The core's bus mux selects these outputs while busy is high.
module dma_copy_engine #(
  parameter int ADDR_WIDTH = 30,
  parameter int LEN_WIDTH  = 13
) (
  input  logic                  clk,
  input  logic                  async_rst_n,
  input  logic                  clk_en,
  input  logic                  start,
  input  logic                  fill_mode,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [LEN_WIDTH-1:0]  length,
  input  logic [31:0]           fill_value,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic [LEN_WIDTH-1:0]  words_left,
  output logic                  bus_lock,
  output logic                  memory_mode,
  output logic [ADDR_WIDTH-1:0] data_address,
  output logic [3:0]            data_mask,
  output logic [31:0]           data_out,
  input  logic [31:0]           data_in
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_LATCH,
    S_WR,
    S_FIN
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] src_ptr;
  logic [ADDR_WIDTH-1:0] dst_ptr;
  logic [31:0]           fill_reg;
  logic                  fill_q;
  logic                  abort_pend;
  logic                  last_word;
  logic                  abort_hit;

  // The write in flight is the final one when exactly one word remains.
  assign last_word = (words_left == LEN_WIDTH'(1));
  // An abort seen earlier in this word, or right now, ends the transfer.
  assign abort_hit = abort | abort_pend;

  // Control FSM with registered bus outputs; data_out doubles as the
  // read-data buffer, since a copied word goes straight out on the next write.
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      state        <= S_IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      aborted      <= 1'b0;
      bus_lock     <= 1'b0;
      memory_mode  <= 1'b0;
      data_mask    <= 4'h0;
      data_address <= '0;
      data_out     <= '0;
      words_left   <= '0;
      abort_pend   <= 1'b0;
    end else if (clk_en) begin
      done        <= 1'b0;
      aborted     <= 1'b0;
      bus_lock    <= 1'b0;
      memory_mode <= 1'b0;
      data_mask   <= 4'h0;
      case (state)
        S_IDLE: begin
          if (start) begin
            busy       <= 1'b1;
            words_left <= length;
            abort_pend <= 1'b0;
            if (length == LEN_WIDTH'(0)) begin
              state <= S_FIN;
            end else if (fill_mode) begin
              state        <= S_WR;
              bus_lock     <= 1'b1;
              memory_mode  <= 1'b1;
              data_mask    <= 4'hF;
              data_address <= dst_addr;
              data_out     <= fill_value;
            end else begin
              state        <= S_RD;
              bus_lock     <= 1'b1;
              data_mask    <= 4'hF;
              data_address <= src_addr;
            end
          end
        end
        S_RD: begin
          // The read completes regardless; abort only takes effect after LATCH.
          if (abort) abort_pend <= 1'b1;
          state <= S_LATCH;
        end
        S_LATCH: begin
          if (abort_pend) begin
            state <= S_FIN;
          end else begin
            if (abort) abort_pend <= 1'b1;
            state        <= S_WR;
            bus_lock     <= 1'b1;
            memory_mode  <= 1'b1;
            data_mask    <= 4'hF;
            data_address <= dst_ptr;
            data_out     <= data_in;
          end
        end
        S_WR: begin
          words_left <= words_left - LEN_WIDTH'(1);
          if (last_word) begin
            // Every word went out, so this is a normal completion.
            abort_pend <= 1'b0;
            state      <= S_FIN;
          end else if (abort_hit) begin
            abort_pend <= 1'b1;
            state      <= S_FIN;
          end else if (fill_q) begin
            bus_lock     <= 1'b1;
            memory_mode  <= 1'b1;
            data_mask    <= 4'hF;
            data_address <= dst_ptr + ADDR_WIDTH'(1);
            data_out     <= fill_reg;
          end else begin
            state        <= S_RD;
            bus_lock     <= 1'b1;
            data_mask    <= 4'hF;
            data_address <= src_ptr;
          end
        end
        S_FIN: begin
          busy       <= 1'b0;
          done       <= ~abort_pend;
          aborted    <= abort_pend;
          abort_pend <= 1'b0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Command capture and address pointers; pure datapath, so no reset.
  always_ff @(posedge clk) begin
    if (clk_en) begin
      case (state)
        S_IDLE: begin
          if (start) begin
            src_ptr  <= src_addr;
            dst_ptr  <= dst_addr;
            fill_reg <= fill_value;
            fill_q   <= fill_mode;
          end
        end
        S_LATCH: src_ptr <= src_ptr + ADDR_WIDTH'(1);
        S_WR:    dst_ptr <= dst_ptr + ADDR_WIDTH'(1);
        default: ;
      endcase
    end
  end

endmodule
